// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer sitting between the uart core and the CPU I/O decode
// (data at 0x0001, status at 0x0002). Each byte the uart flags with rx_new is
// pulled into a small FIFO and acknowledged, so receive bursts survive while
// the CPU is busy. Everything runs on posedge of the cpu_clk domain.
//
// Optional feature macro: RXF_IRQ_EN
//   defined   : irq is a registered "occupancy >= IRQ_LEVEL" flag, computed
//               from the next-state count so it tracks count cycle-exactly.
//   undefined : irq is tied low and IRQ_LEVEL has no effect.
//
// Parameters
//   DEPTH_LOG2 : FIFO depth is 2**DEPTH_LOG2 entries
//   IRQ_LEVEL  : occupancy threshold for irq, 1..2**DEPTH_LOG2
//
// Ports
//   clk      in   cpu clock
//   rst      in   synchronous active-high reset
//   rx_new   in   uart "byte available" level, held until acknowledged
//   rx_data  in   uart byte, stable while rx_new is high
//   rx_ack   out  one-cycle registered pulse to the uart read strobe
//   rd_pop   in   bus read-done strobe, pops the head entry
//   rd_data  out  head byte, 8'h00 when empty
//   status   out  {5'b0, ovf, full, nonempty}
//   clr_ovf  in   clears the sticky overflow flag
//   count    out  current occupancy 0..2**DEPTH_LOG2
//   irq      out  receive interrupt
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_new,
    input  logic [7:0]            rx_data,
    output logic                  rx_ack,
    input  logic                  rd_pop,
    output logic [7:0]            rd_data,
    output logic [7:0]            status,
    input  logic                  clr_ovf,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  irq
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Reject a threshold that could never be met or is always met from empty.
    if ((IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_bad_irq_level
        $error("uart_rx_fifo: IRQ_LEVEL must be within 1..2**DEPTH_LOG2");
    end

    // IDLE takes a byte when rx_new is seen; WAIT_LO blocks until the uart
    // drops rx_new so a slow de-assert cannot cause a second push.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_LO = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    take_s;
    logic                    rx_ack_r;

    logic [7:0]              mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [DEPTH_LOG2:0]     count_r;
    logic [DEPTH_LOG2:0]     count_nxt_s;
    logic                    ovf_r;
    logic                    ovf_nxt_s;

    logic                    full_s;
    logic                    nonempty_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    overflow_s;
    logic [7:0]              rd_data_s;

    assign full_s     = (count_r == FULL_COUNT);
    assign nonempty_s = (count_r != '0);

    // Ingest FSM next state; take_s marks the single cycle a byte is accepted.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_new) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_WAIT_LO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!rx_new) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_LO;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and the registered acknowledge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rx_ack_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rx_ack_r <= take_s;
        end
    end

    // Push/pop decisions and next occupancy. A pop on a full FIFO frees the
    // slot the coinciding push needs, so that case is not an overflow.
    always_comb begin
        pop_s      = rd_pop & nonempty_s;
        push_s     = 1'b0;
        overflow_s = 1'b0;
        if (take_s) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                overflow_s = 1'b1;
            end
        end else begin
            push_s     = 1'b0;
            overflow_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // A new overflow wins over a coinciding clear.
        if (overflow_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // Head byte, forced to zero when nothing is buffered.
    always_comb begin
        rd_data_s = 8'h00;
        if (nonempty_s) begin
            rd_data_s = mem_r[rd_ptr_r];
        end else begin
            rd_data_s = 8'h00;
        end
    end

`ifdef RXF_IRQ_EN
    localparam logic [DEPTH_LOG2:0] IRQ_LEVEL_C = IRQ_LEVEL[DEPTH_LOG2:0];

    logic irq_r;

    // Interrupt follows the occupancy the FIFO is about to have.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (count_nxt_s >= IRQ_LEVEL_C);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    assign rx_ack  = rx_ack_r;
    assign rd_data = rd_data_s;
    assign count   = count_r;
    assign status  = {5'b00000, ovf_r, full_s, nonempty_s};

endmodule
